// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types and constants for the SLC-3 front-panel input stage
package lc3b_types;

  // Number of flops between an asynchronous pin and the first logic that looks at it.
  localparam int KEY_SYNC_STAGES = 2;

  // Per-button debounce state: stable in either level, or counting towards the other one.
  typedef enum logic [1:0] {
    STABLE_UP   = 2'd0,
    WAIT_DOWN   = 2'd1,
    STABLE_DOWN = 2'd2,
    WAIT_UP     = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one button channel: synchroniser, debounce FSM, optional auto-repeat (KEY_REPEAT_EN)
module key_debounce
  import lc3b_types::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_next_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [KEY_SYNC_STAGES-1:0] sync_q;
  logic                       synced;
  key_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       level_q, level_d;
  logic                       press_q, press_d;
  logic                       release_q, release_d;

`ifdef KEY_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] FIRST_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] NEXT_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              first_q, first_d;
`else
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_CYCLES;
`endif

  // Raw pin is active-low; the chain idles at 1 so reset looks like a released key.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[KEY_SYNC_STAGES-2:0], key_n_i};
    end
  end

  assign synced = sync_q[KEY_SYNC_STAGES-1];

  // State, counter and registered level/pulse outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= STABLE_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_q    <= '0;
      first_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_REPEAT_EN
      hold_q    <= hold_d;
      first_q   <= first_d;
`endif
    end
  end

  // Next-state: a change commits only after DEBOUNCE_CYCLES consecutive synced samples.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    hold_d    = hold_q;
    first_d   = first_q;
`endif
    case (state_q)
      STABLE_UP: begin
        if (!synced) begin
          state_d = WAIT_DOWN;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_DOWN: begin
        if (synced) begin
          state_d = STABLE_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_DOWN;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef KEY_REPEAT_EN
          hold_d  = '0;
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_DOWN: begin
        if (synced) begin
          state_d = WAIT_UP;
          cnt_d   = CNT_ONE;
        end
`ifdef KEY_REPEAT_EN
        // Held: first repeat after REPEAT_DELAY, then every REPEAT_CYCLES.
        else if (hold_q == (first_q ? FIRST_LAST : NEXT_LAST)) begin
          press_d = 1'b1;
          hold_d  = '0;
          first_d = 1'b0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
`endif
      end
      WAIT_UP: begin
        if (!synced) begin
          state_d = STABLE_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_UP;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
`ifdef KEY_REPEAT_EN
          hold_d    = '0;
          first_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_UP;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - front-panel button/switch conditioner for the SLC-3 (auto-repeat via KEY_REPEAT_EN)
module key_conditioner
  import lc3b_types::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [15:0]       Switches_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [15:0]       Switches_sync,
  output logic [15:0]       Switches_snap
);

  logic [N_KEYS-1:0] press_next;
  logic [15:0]       sw_meta_q, sw_sync_q, snap_q;
  logic              unused_press_next;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_debounce (
      .Clk         (Clk),
      .Reset       (Reset),
      .key_n_i     (key_n[g]),
      .level_o     (key_level[g]),
      .press_o     (key_press[g]),
      .release_o   (key_release[g]),
      .press_next_o(press_next[g])
    );
  end

  // Only the Run channel drives the snapshot; the other look-ahead bits are spare.
  assign unused_press_next = ^press_next;

  // Two-flop switch synchroniser; snapshot loads on the edge that raises key_press[0].
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      snap_q    <= '0;
    end else begin
      sw_meta_q <= Switches_raw;
      sw_sync_q <= sw_meta_q;
      if (press_next[0]) begin
        snap_q <= sw_sync_q;
      end
    end
  end

  assign Switches_sync = sw_sync_q;
  assign Switches_snap = snap_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner (table, directed, random vs model)
module tb_key_conditioner;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RC = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  key_n;
  logic [15:0] sw;
  logic [1:0]  key_level, key_press, key_release;
  logic [15:0] sw_sync, sw_snap;

  int total = 0;
  int bad   = 0;

  key_conditioner #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_CYCLES(RC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .key_n(key_n), .Switches_raw(sw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .Switches_sync(sw_sync), .Switches_snap(sw_snap)
  );

  always #5 Clk = ~Clk;

  // Reference model: pin delay, and a run of consecutive samples that disagree with the level.
  logic [1:0]  m_s1, m_s2, m_level, m_press, m_release;
  logic [15:0] m_sw1, m_sw2, m_snap;
  int          m_run [2];
`ifdef KEY_REPEAT_EN
  int          m_hold [2];
  int          m_target [2];
`endif

  task automatic model_clear();
    m_s1 = 2'b11; m_s2 = 2'b11;
    m_sw1 = '0; m_sw2 = '0; m_snap = '0;
    m_level = '0; m_press = '0; m_release = '0;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0;
`ifdef KEY_REPEAT_EN
      m_hold[k] = 0; m_target[k] = RD;
`endif
    end
  endtask

  task automatic model_edge();
    logic [1:0] np, nr;
    logic held;
    if (!Reset) begin
      model_clear();
      return;
    end
    np = '0; nr = '0;
    for (int k = 0; k < 2; k++) begin
      held = ~m_s2[k];
`ifdef KEY_REPEAT_EN
      if (m_level[k] && m_run[k] == 0 && held) begin
        m_hold[k]++;
        if (m_hold[k] == m_target[k]) begin
          np[k] = 1'b1; m_hold[k] = 0; m_target[k] = RC;
        end
      end
`endif
      if (held != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DC) begin
          m_level[k] = held;
          m_run[k] = 0;
          if (held) np[k] = 1'b1; else nr[k] = 1'b1;
`ifdef KEY_REPEAT_EN
          m_hold[k] = 0; m_target[k] = RD;
`endif
        end
      end else begin
        m_run[k] = 0;
      end
    end
    if (np[0]) m_snap = m_sw2;
    m_press = np; m_release = nr;
    m_s2 = m_s1; m_s1 = key_n;
    m_sw2 = m_sw1; m_sw1 = sw;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check("cycle", 64'({key_level, key_press, key_release, sw_sync, sw_snap}),
          64'({m_level, m_press, m_release, m_sw2, m_snap}));
    check("press_and_release", 64'(key_press & key_release), 64'd0);
  endtask

  typedef struct {
    logic        rst_n;
    logic [1:0]  kn;
    logic [15:0] swv;
    int          cyc;
    logic [1:0]  lvl;
    int          p0, p1, r0, r1;
    logic [15:0] sync, snap;
  } vec_t;

  vec_t tbl [13];
  int   p0c, p1c, r0c, r1c, n, left [2];
  bit   found;

  initial begin
    Reset = 1'b0; key_n = 2'b11; sw = 16'hFFFF;
    model_clear();

    tbl[0]  = '{1'b0, 2'b11, 16'hFFFF,  3, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 2'b11, 16'hFFFF, 20, 2'b00, 0, 0, 0, 0, 16'hFFFF, 16'h0000};
    tbl[2]  = '{1'b1, 2'b10, 16'h3A5C, 10, 2'b01, 1, 0, 0, 0, 16'h3A5C, 16'h3A5C};
    tbl[3]  = '{1'b1, 2'b11, 16'h3A5C, 10, 2'b00, 0, 0, 1, 0, 16'h3A5C, 16'h3A5C};
    tbl[4]  = '{1'b1, 2'b01, 16'h3A5C,  3, 2'b00, 0, 0, 0, 0, 16'h3A5C, 16'h3A5C};
    tbl[5]  = '{1'b1, 2'b11, 16'h3A5C,  1, 2'b00, 0, 0, 0, 0, 16'h3A5C, 16'h3A5C};
    tbl[6]  = '{1'b1, 2'b01, 16'h3A5C,  3, 2'b00, 0, 0, 0, 0, 16'h3A5C, 16'h3A5C};
    tbl[7]  = '{1'b1, 2'b11, 16'h3A5C, 10, 2'b00, 0, 0, 0, 0, 16'h3A5C, 16'h3A5C};
    tbl[8]  = '{1'b1, 2'b00, 16'h1234, 10, 2'b11, 1, 1, 0, 0, 16'h1234, 16'h1234};
    tbl[9]  = '{1'b1, 2'b11, 16'h1234, 10, 2'b00, 0, 0, 1, 1, 16'h1234, 16'h1234};
    tbl[10] = '{1'b1, 2'b00, 16'hBEEF,  6, 2'b11, 1, 1, 0, 0, 16'hBEEF, 16'hBEEF};
    tbl[11] = '{1'b1, 2'b10, 16'hBEEF,  5, 2'b11, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF};
    tbl[12] = '{1'b1, 2'b11, 16'hBEEF,  8, 2'b00, 0, 0, 1, 1, 16'hBEEF, 16'hBEEF};

    for (int i = 0; i < 13; i++) begin
      Reset = tbl[i].rst_n; key_n = tbl[i].kn; sw = tbl[i].swv;
      if (!Reset) model_clear();
      p0c = 0; p1c = 0; r0c = 0; r1c = 0;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step();
        p0c += int'(key_press[0]); p1c += int'(key_press[1]);
        r0c += int'(key_release[0]); r1c += int'(key_release[1]);
      end
      check($sformatf("row%0d_level", i), 64'(key_level), 64'(tbl[i].lvl));
      check($sformatf("row%0d_press", i), 64'({p1c[15:0], p0c[15:0]}), 64'({tbl[i].p1[15:0], tbl[i].p0[15:0]}));
      check($sformatf("row%0d_release", i), 64'({r1c[15:0], r0c[15:0]}), 64'({tbl[i].r1[15:0], tbl[i].r0[15:0]}));
      check($sformatf("row%0d_sync", i), 64'(sw_sync), 64'(tbl[i].sync));
      check($sformatf("row%0d_snap", i), 64'(sw_snap), 64'(tbl[i].snap));
    end

    // Random glitchy buttons and changing switches against the model.
    left[0] = 0; left[1] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (left[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          left[k] = int'($urandom_range(1, 9));
        end else begin
          left[k]--;
        end
      end
      if (c % 16 == 0) sw = 16'($urandom);
      step();
    end

    // Reset mid-debounce: asynchronous clear, then a full debounce period after release.
    key_n = 2'b11; sw = 16'hA5A5;
    repeat (10) step();
    key_n = 2'b10;
    repeat (5) step();
    #2;
    Reset = 1'b0;
    model_clear();
    #1;
    check("async_clear", 64'({key_level, key_press, key_release, sw_sync, sw_snap}), 64'd0);
    repeat (2) step();
    Reset = 1'b1;
    n = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      n++;
      if (key_press[0]) found = 1'b1;
    end
    check("press_after_reset", 64'(n), 64'd6);

`ifdef KEY_REPEAT_EN
    key_n = 2'b11;
    repeat (10) step();
    key_n = 2'b10; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (key_press[0]) found = 1'b1;
    end
    check("repeat_commit", 64'(found), 64'd1);
    n = 0;
    repeat (20) begin
      sw = 16'($urandom);
      step();
      n += int'(key_press[0]);
    end
    check("repeat_count", 64'(n), 64'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
